// File: rtl/bcd_encoder_seq_if.sv
// rtl/bcd_encoder_seq_if.sv - stream handshake bundle for the iterative binary-to-BCD converter
// Purpose: groups the input stream (i_valid/o_ready/i_bin), the output stream
//          (o_valid/i_ready/o_bcd) and the o_busy status of bcd_encoder_seq.
// Ports (signals):
//   i_valid, i_bin[N-1:0]  upstream value offer
//   o_ready                converter can accept (idle)
//   o_valid, o_bcd[W-1:0]  finished packed BCD result, digit k at [4k+3:4k]
//   i_ready                downstream takes the result
//   o_busy                 conversion in progress
// Modports: slave = converter side, master = producer/consumer side.
interface bcd_encoder_seq_if #(
  parameter int N = 8
);
  localparam int W = N + (N - 4) / 3 + 1;

  logic         i_valid;
  logic         o_ready;
  logic [N-1:0] i_bin;
  logic         o_valid;
  logic         i_ready;
  logic [W-1:0] o_bcd;
  logic         o_busy;

  modport slave (
    input  i_valid, i_bin, i_ready,
    output o_ready, o_valid, o_bcd, o_busy
  );

  modport master (
    output i_valid, i_bin, i_ready,
    input  o_ready, o_valid, o_bcd, o_busy
  );
endinterface

// File: rtl/bcd_encoder_seq.sv
// rtl/bcd_encoder_seq.sv - iterative shift-and-add-3 binary-to-BCD converter, one bit per clock
// Purpose: converts an N-bit unsigned value to packed BCD in exactly N shift cycles,
//          with valid/ready handshakes on both input and output.
// Ports:
//   i_clock    rising-edge clock
//   i_aresetn  asynchronous active-low reset
//   bus        bcd_encoder_seq_if.slave (i_valid/o_ready/i_bin in, o_valid/i_ready/o_bcd out, o_busy)
module bcd_encoder_seq #(
  parameter int N = 8
) (
  input  logic              i_clock,
  input  logic              i_aresetn,
  bcd_encoder_seq_if.slave  bus
);
  localparam int W  = N + (N - 4) / 3 + 1;
  localparam int CW = $clog2(N + 1);
  localparam int SW = W + N;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   sr_q, sr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    bcd_q, bcd_d;
  logic [W-1:0]    hi_adj;
  logic [SW-1:0]   shifted;

  always_ff @(posedge i_clock or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;

    // Add-3 correction on every full digit nibble; the partial top group
    // (W mod 4 bits) can never exceed 4 and is left untouched.
    hi_adj = sr_q[SW-1:N];
    for (int k = 0; k < W / 4; k++) begin
      if (hi_adj[4*k +: 4] > 4'd4) begin
        hi_adj[4*k +: 4] = hi_adj[4*k +: 4] + 4'd3;
      end
    end
    shifted = {hi_adj, sr_q[N-1:0]} << 1;

    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          sr_d    = {{W{1'b0}}, bus.i_bin};
          cnt_d   = CW'(N);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = shifted;
        cnt_d = cnt_q - CW'(1);
        // o_bcd only ever sees the fully converted value
        if (cnt_q == CW'(1)) begin
          bcd_d   = shifted[SW-1:N];
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status decoded straight from state so reset clears them without a clock
  assign bus.o_ready = (state_q == IDLE);
  assign bus.o_valid = (state_q == DONE);
  assign bus.o_busy  = (state_q == SHIFT);
  assign bus.o_bcd   = bcd_q;
endmodule

// File: tb/tb_bcd_encoder_seq.sv
// tb/tb_bcd_encoder_seq.sv - self-checking bench for bcd_encoder_seq (N=8 and N=16 instances)
module tb_bcd_encoder_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  bcd_encoder_seq_if #(.N(8))  b8 ();
  bcd_encoder_seq_if #(.N(16)) b16 ();

  bcd_encoder_seq #(.N(8))  dut8  (.i_clock(clk), .i_aresetn(rst_n), .bus(b8));
  bcd_encoder_seq #(.N(16)) dut16 (.i_clock(clk), .i_aresetn(rst_n), .bus(b16));

  typedef struct {
    logic [15:0] bin;
    logic [23:0] exp;
    bit          wide;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [63:0] to_bcd(input longint unsigned v);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      r = r | (64'(v % 10) << (4 * k));
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic conv8(input logic [7:0] v, input logic [63:0] exp, input string nm);
    int lat;
    @(negedge clk);
    chk({nm, "_rdy"}, 64'(b8.o_ready), 64'd1);
    b8.i_valid = 1'b1; b8.i_bin = v;
    @(negedge clk);
    b8.i_valid = 1'b0; b8.i_bin = 8'($urandom);
    chk({nm, "_busy"}, 64'(b8.o_busy), 64'd1);
    lat = 0;
    while (!b8.o_valid && lat < 40) begin
      @(negedge clk); lat++;
    end
    chk({nm, "_lat"}, 64'(lat), 64'd8);
    chk({nm, "_bcd"}, 64'(b8.o_bcd), exp);
    b8.i_ready = 1'b1;
    @(negedge clk);
    b8.i_ready = 1'b0;
    chk({nm, "_ordy"}, 64'(b8.o_ready), 64'd1);
    chk({nm, "_vld0"}, 64'(b8.o_valid), 64'd0);
  endtask

  task automatic conv16(input logic [15:0] v, input logic [63:0] exp, input string nm);
    int lat;
    @(negedge clk);
    b16.i_valid = 1'b1; b16.i_bin = v;
    @(negedge clk);
    b16.i_valid = 1'b0; b16.i_bin = 16'($urandom);
    lat = 0;
    while (!b16.o_valid && lat < 60) begin
      @(negedge clk); lat++;
    end
    chk({nm, "_lat"}, 64'(lat), 64'd16);
    chk({nm, "_bcd"}, 64'(b16.o_bcd), exp);
    b16.i_ready = 1'b1;
    @(negedge clk);
    b16.i_ready = 1'b0;
    chk({nm, "_ordy"}, 64'(b16.o_ready), 64'd1);
  endtask

  initial begin
    int lat;
    int accepts;
    int results;
    logic [7:0] expq[$];

    b8.i_valid = 0; b8.i_bin = '0; b8.i_ready = 0;
    b16.i_valid = 0; b16.i_bin = '0; b16.i_ready = 0;

    // table of hand-computed decimal results
    tbl.push_back('{16'd255,   24'h000255, 1'b0});
    tbl.push_back('{16'd0,     24'h000000, 1'b0});
    tbl.push_back('{16'd99,    24'h000099, 1'b0});
    tbl.push_back('{16'd37,    24'h000037, 1'b0});
    tbl.push_back('{16'd100,   24'h000100, 1'b0});
    tbl.push_back('{16'hFFFF,  24'h065535, 1'b1});
    tbl.push_back('{16'd10000, 24'h010000, 1'b1});
    tbl.push_back('{16'd0,     24'h000000, 1'b1});
    tbl.push_back('{16'd9999,  24'h009999, 1'b1});

    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(b8.o_ready), 64'd1);
    chk("rst_valid", 64'(b8.o_valid), 64'd0);
    chk("rst_busy",  64'(b8.o_busy),  64'd0);
    chk("rst_bcd",   64'(b8.o_bcd),   64'd0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      if (tbl[i].wide) conv16(tbl[i].bin, 64'(tbl[i].exp), $sformatf("tbl%0d", i));
      else             conv8(tbl[i].bin[7:0], 64'(tbl[i].exp), $sformatf("tbl%0d", i));
    end

    // i_ready while nothing is valid has no effect
    @(negedge clk); b8.i_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_rdy_ready", 64'(b8.o_ready), 64'd1);
    chk("idle_rdy_valid", 64'(b8.o_valid), 64'd0);
    b8.i_ready = 1'b0;

    // hold result with i_ready low; stray i_valid pulses must be ignored
    @(negedge clk);
    b8.i_valid = 1'b1; b8.i_bin = 8'd123;
    @(negedge clk);
    lat = 0;
    while (!b8.o_valid && lat < 40) begin
      b8.i_valid = lat[0]; b8.i_bin = 8'($urandom);
      @(negedge clk); lat++;
    end
    chk("hold_lat", 64'(lat), 64'd8);
    for (int c = 0; c < 5; c++) begin
      b8.i_valid = 1'b1; b8.i_bin = 8'($urandom);
      @(negedge clk);
      chk($sformatf("hold_vld%0d", c), 64'(b8.o_valid), 64'd1);
      chk($sformatf("hold_bcd%0d", c), 64'(b8.o_bcd), 64'h123);
      chk($sformatf("hold_rdy%0d", c), 64'(b8.o_ready), 64'd0);
    end
    b8.i_valid = 1'b0; b8.i_ready = 1'b1;
    @(negedge clk);
    b8.i_ready = 1'b0;
    repeat (12) @(negedge clk);
    chk("hold_no_second", 64'(b8.o_valid), 64'd0);
    chk("hold_idle_rdy", 64'(b8.o_ready), 64'd1);

    // reset in the middle of a conversion of 200
    @(negedge clk);
    b8.i_valid = 1'b1; b8.i_bin = 8'd200;
    @(negedge clk);
    b8.i_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(b8.o_valid), 64'd0);
    chk("arst_bcd",   64'(b8.o_bcd),   64'd0);
    chk("arst_ready", 64'(b8.o_ready), 64'd1);
    chk("arst_busy",  64'(b8.o_busy),  64'd0);
    @(negedge clk); rst_n = 1'b1;
    conv8(8'd37, 64'h037, "post_rst");

    // exhaustive 0..255 with random gaps on both sides, decimal scoreboard
    accepts = 0; results = 0;
    fork
      begin
        for (int v = 0; v < 256; v++) begin
          int guard;
          @(negedge clk);
          repeat ($urandom_range(0, 2)) @(negedge clk);
          guard = 0;
          while (!b8.o_ready && guard < 100) begin
            @(negedge clk); guard++;
          end
          b8.i_valid = 1'b1; b8.i_bin = 8'(v);
          expq.push_back(8'(v));
          accepts++;
          @(negedge clk);
          b8.i_valid = 1'b0; b8.i_bin = 8'($urandom);
        end
      end
      begin
        int cyc;
        cyc = 0;
        while (results < 256 && cyc < 20000) begin
          @(negedge clk); cyc++;
          b8.i_ready = 1'($urandom_range(0, 1));
          if (b8.o_valid && b8.i_ready) begin
            if (expq.size() == 0) chk("rand_unexpected", 64'(b8.o_bcd), 64'hFFFF);
            else chk($sformatf("rand_%0d", expq[0]), 64'(b8.o_bcd), to_bcd(longint'(expq.pop_front())));
            results++;
          end
        end
        if (cyc >= 20000) chk("rand_timeout", 64'(results), 64'd256);
        b8.i_ready = 1'b0;
      end
    join
    chk("rand_accepts", 64'(accepts), 64'd256);
    chk("rand_count_eq", 64'(results), 64'(accepts));

    // random wide values against the decimal model
    for (int i = 0; i < 6; i++) begin
      logic [15:0] r;
      r = 16'($urandom);
      conv16(r, to_bcd(longint'(r)), $sformatf("w%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
